// File: rtl/ssm_pkg.sv
// Shared FSM encoding and elaboration helpers for the SSM tile scheduler.
package ssm_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_WAIT  = 3'd3,
    S_STORE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Index width with a floor of one bit so degenerate single-tile axes still get a register.
  function automatic int f_wid(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit f_div_ok(input int n, input int t);
    return (t > 0) && ((n % t) == 0);
  endfunction

  function automatic int f_ntiles(input int n, input int t);
    return n / t;
  endfunction

endpackage

// File: rtl/ssm_tile_scheduler_if.sv
// Handshake bundle between the tile scheduler and its loader/core/write-back neighbours.
interface ssm_tile_scheduler_if #(
  parameter int HW = 5,
  parameter int PW = 6,
  parameter int TW = 1
);
  logic          start;
  logic          done;
  logic          busy;
  logic          ld_req;
  logic          ld_ack;
  logic          core_start;
  logic          core_done;
  logic          wb_valid;
  logic          wb_ready;
  logic [HW-1:0] tile_h_base;
  logic [PW-1:0] tile_p_base;
  logic [TW-1:0] tile_cnt;

  modport master (
    input  start, ld_ack, core_done, wb_ready,
    output done, busy, ld_req, core_start, wb_valid, tile_h_base, tile_p_base, tile_cnt
  );

  modport slave (
    output start, ld_ack, core_done, wb_ready,
    input  done, busy, ld_req, core_start, wb_valid, tile_h_base, tile_p_base, tile_cnt
  );
endinterface

// File: rtl/tile_index_counter.sv
// Nested head/channel tile counter, channel innermost; bases are index times a constant tile size.
module tile_index_counter import ssm_pkg::*; #(
  parameter int H_TILE = 24,
  parameter int P_TILE = 64,
  parameter int NH_T   = 1,
  parameter int NP_T   = 1,
  parameter int HW     = 5,
  parameter int PW     = 6,
  parameter int HIW    = f_wid(NH_T),
  parameter int PIW    = f_wid(NP_T)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_adv,
  output logic          o_last,
  output logic [HW-1:0] o_h_base,
  output logic [PW-1:0] o_p_base
);

  logic [HIW-1:0] r_h_idx;
  logic [PIW-1:0] r_p_idx;
  logic           w_p_wrap;

  assign w_p_wrap = (r_p_idx == PIW'(NP_T - 1));
  assign o_last   = w_p_wrap && (r_h_idx == HIW'(NH_T - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_h_idx <= '0;
      r_p_idx <= '0;
    end else if (i_adv) begin
      if (w_p_wrap) begin
        r_p_idx <= '0;
        r_h_idx <= r_h_idx + HIW'(1);
      end else begin
        r_p_idx <= r_p_idx + PIW'(1);
      end
    end
  end

  assign o_h_base = HW'(32'(r_h_idx) * H_TILE);
  assign o_p_base = PW'(32'(r_p_idx) * P_TILE);

endmodule

// File: rtl/ssm_tile_scheduler.sv
// Walks every (head, channel) tile of one SSM step through load -> compute -> write-back,
// one tile in flight; all outputs come from registers or a decode of the state register.
module ssm_tile_scheduler import ssm_pkg::*; #(
  parameter int H      = 24,
  parameter int P      = 64,
  parameter int H_tile = 24,
  parameter int P_tile = 64,
  parameter int HW     = f_wid(H),
  parameter int PW     = f_wid(P),
  parameter int TW     = $clog2((H / H_tile) * (P / P_tile) + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  ssm_tile_scheduler_if.master  sched_if
);

  localparam int NH_T = f_ntiles(H, H_tile);
  localparam int NP_T = f_ntiles(P, P_tile);

  if (!f_div_ok(H, H_tile)) begin : g_chk_h
    $error("H must be a multiple of H_tile");
  end
  if (!f_div_ok(P, P_tile)) begin : g_chk_p
    $error("P must be a multiple of P_tile");
  end

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_clr;
  logic          w_adv;
  logic          w_accept;
  logic          w_last;
  logic [HW-1:0] w_h_base;
  logic [PW-1:0] w_p_base;
  logic [TW-1:0] r_tile_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_adv       = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sched_if.start) begin
          w_clr       = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD:  if (sched_if.ld_ack) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_WAIT;
      S_WAIT:  if (sched_if.core_done) w_state_nxt = S_STORE;
      S_STORE: begin
        if (sched_if.wb_ready) begin
          w_accept = 1'b1;
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_adv       = 1'b1;
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Indices only move on the STORE->LOAD hop, so bases hold for a whole tile.
  tile_index_counter #(
    .H_TILE (H_tile),
    .P_TILE (P_tile),
    .NH_T   (NH_T),
    .NP_T   (NP_T),
    .HW     (HW),
    .PW     (PW)
  ) u_idx (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_adv    (w_adv),
    .o_last   (w_last),
    .o_h_base (w_h_base),
    .o_p_base (w_p_base)
  );

  always_ff @(posedge clk) begin
    if (rst || w_clr)  r_tile_cnt <= '0;
    else if (w_accept) r_tile_cnt <= r_tile_cnt + TW'(1);
  end

  assign sched_if.busy        = (r_state != S_IDLE);
  assign sched_if.ld_req      = (r_state == S_LOAD);
  assign sched_if.core_start  = (r_state == S_RUN);
  assign sched_if.wb_valid    = (r_state == S_STORE);
  assign sched_if.done        = (r_state == S_DONE);
  assign sched_if.tile_h_base = w_h_base;
  assign sched_if.tile_p_base = w_p_base;
  assign sched_if.tile_cnt    = r_tile_cnt;

endmodule

// File: tb/tb_ssm_tile_scheduler.sv
// Directed bench: an 8-tile instance (H_tile=12, P_tile=16) and a default single-tile instance.
module tb_ssm_tile_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic sel;
  logic t_start, t_ld_ack, t_core_done, t_wb_ready;
  int   n_vec, n_err;

  ssm_tile_scheduler_if #(.HW(5), .PW(6), .TW(4)) ifa ();
  ssm_tile_scheduler_if #(.HW(5), .PW(6), .TW(1)) ifb ();

  ssm_tile_scheduler #(.H(24), .P(64), .H_tile(12), .P_tile(16)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .sched_if (ifa)
  );

  ssm_tile_scheduler dut_b (
    .clk      (clk),
    .rst      (rst),
    .sched_if (ifb)
  );

  assign ifa.start     = t_start     & ~sel;
  assign ifa.ld_ack    = t_ld_ack    & ~sel;
  assign ifa.core_done = t_core_done & ~sel;
  assign ifa.wb_ready  = t_wb_ready  & ~sel;
  assign ifb.start     = t_start     & sel;
  assign ifb.ld_ack    = t_ld_ack    & sel;
  assign ifb.core_done = t_core_done & sel;
  assign ifb.wb_ready  = t_wb_ready  & sel;

  logic        o_busy, o_done, o_ld_req, o_cs, o_wbv;
  logic [31:0] o_hb, o_pb, o_cnt;
  assign o_busy   = sel ? ifb.busy       : ifa.busy;
  assign o_done   = sel ? ifb.done       : ifa.done;
  assign o_ld_req = sel ? ifb.ld_req     : ifa.ld_req;
  assign o_cs     = sel ? ifb.core_start : ifa.core_start;
  assign o_wbv    = sel ? ifb.wb_valid   : ifa.wb_valid;
  assign o_hb     = sel ? 32'(ifb.tile_h_base) : 32'(ifa.tile_h_base);
  assign o_pb     = sel ? 32'(ifb.tile_p_base) : 32'(ifa.tile_p_base);
  assign o_cnt    = sel ? 32'(ifb.tile_cnt)    : 32'(ifa.tile_cnt);

  int exp_h[8] = '{0, 0, 0, 0, 12, 12, 12, 12};
  int exp_p[8] = '{0, 16, 32, 48, 0, 16, 32, 48};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   32'(o_busy),   0);
    chk({tag, "_done"},   32'(o_done),   0);
    chk({tag, "_ld_req"}, 32'(o_ld_req), 0);
    chk({tag, "_cstart"}, 32'(o_cs),     0);
    chk({tag, "_wbv"},    32'(o_wbv),    0);
    chk({tag, "_hbase"},  o_hb,          0);
    chk({tag, "_pbase"},  o_pb,          0);
    chk({tag, "_cnt"},    o_cnt,         0);
  endtask

  // bp: random 0-7 cycle ld_ack/wb_ready delays; spur: stray start/core_done;
  // rst_tile: pulse rst in WAIT once this many tiles are done (-1 = never).
  task automatic run_step(input bit bp, input bit spur, input int rst_tile,
                          input int nt, input int exp_done_cyc);
    int cyc, k, n_cs, ld_wait, wb_wait, ld_dly, wb_dly;
    logic [31:0] hb, pb;
    bit prev_cs, prev_ld_req, prev_ld_ack, prev_wbv, prev_wbr, seen_done, in_wait;
    @(negedge clk);
    t_start = 1'b1; t_ld_ack = !bp; t_wb_ready = !bp; t_core_done = 1'b0;
    k = 0; n_cs = 0; ld_wait = 0; wb_wait = 0; hb = 0; pb = 0;
    ld_dly = bp ? int'($urandom_range(7)) : 0;
    wb_dly = bp ? int'($urandom_range(7)) : 0;
    prev_cs = 0; prev_ld_req = 0; prev_ld_ack = 0; prev_wbv = 0; prev_wbr = 0;
    seen_done = 0; cyc = 0;
    while (!seen_done && cyc < 1500) begin
      @(negedge clk);
      cyc++;
      t_start = 1'b0;
      if (cyc == 1) begin
        chk("start_busy", 32'(o_busy), 1);
        chk("start_ld_req", 32'(o_ld_req), 1);
        chk("start_cnt_clear", o_cnt, 0);
      end
      if (prev_ld_req && !prev_ld_ack) chk("ld_req_hold", 32'(o_ld_req), 1);
      if (prev_wbv && !prev_wbr)       chk("wb_valid_hold", 32'(o_wbv), 1);
      if (o_ld_req && !prev_ld_req) begin
        chk("tile_h_base", o_hb, (k < 8) ? 32'(exp_h[k]) : 32'hFFFF);
        chk("tile_p_base", o_pb, (k < 8) ? 32'(exp_p[k]) : 32'hFFFF);
        chk("tile_cnt", o_cnt, 32'(k));
        hb = o_hb; pb = o_pb;
      end else if (o_busy && !o_done) begin
        chk("h_base_hold", o_hb, hb);
        chk("p_base_hold", o_pb, pb);
      end
      if (o_cs) n_cs++;
      in_wait = o_busy && !o_ld_req && !o_cs && !o_wbv && !o_done;
      if (o_done) begin
        seen_done = 1;
        if (exp_done_cyc > 0) chk("done_cycle", 32'(cyc), 32'(exp_done_cyc));
        chk("tiles_done", 32'(k), 32'(nt));
        chk("core_starts", 32'(n_cs), 32'(nt));
        chk("done_cnt", o_cnt, 32'(nt));
      end
      if (in_wait && k == rst_tile) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("rst_mid");
        t_ld_ack = 1'b0; t_wb_ready = 1'b0; t_core_done = 1'b0;
        return;
      end
      if (bp) begin
        t_ld_ack = 1'b0;
        t_wb_ready = 1'b0;
        if (o_ld_req) begin
          if (ld_wait == ld_dly) begin
            t_ld_ack = 1'b1; ld_wait = 0; ld_dly = int'($urandom_range(7));
          end else ld_wait++;
        end
        if (o_wbv) begin
          if (wb_wait == wb_dly) begin
            t_wb_ready = 1'b1; wb_wait = 0; wb_dly = int'($urandom_range(7));
          end else wb_wait++;
        end
      end
      t_core_done = prev_cs;
      if (spur && o_ld_req) t_core_done = 1'b1;
      if (spur && (in_wait || o_wbv)) t_start = 1'b1;
      if (o_wbv && t_wb_ready) k++;
      prev_cs = o_cs; prev_ld_req = o_ld_req; prev_ld_ack = t_ld_ack;
      prev_wbv = o_wbv; prev_wbr = t_wb_ready;
    end
    if (!seen_done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; sel = 1'b0;
    t_start = 1'b0; t_ld_ack = 1'b0; t_core_done = 1'b0; t_wb_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("in_reset");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("after_reset");

    run_step(1'b0, 1'b0, -1, 8, 33);
    run_step(1'b0, 1'b0, -1, 8, 33);
    @(negedge clk);
    chk("idle_after_done_busy", 32'(o_busy), 0);
    chk("idle_after_done_pulse", 32'(o_done), 0);
    run_step(1'b1, 1'b0, -1, 8, 0);
    run_step(1'b1, 1'b0, -1, 8, 0);
    run_step(1'b0, 1'b1, -1, 8, 33);
    run_step(1'b0, 1'b0, 3, 8, 0);
    run_step(1'b0, 1'b0, -1, 8, 33);

    sel = 1'b1;
    @(negedge clk);
    chk_all_zero("single_idle");
    run_step(1'b0, 1'b0, -1, 1, 5);
    run_step(1'b0, 1'b1, -1, 1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
